// File: rtl/fixed_int16_pkg.sv
// Shared sign-magnitude Q1.15 definitions and saturating add helpers.
// Used by the fixed-point adder and by the pipelined subtractor.
package fixed_int16_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned MAG_W = WIDTH - 1;
    localparam logic [MAG_W-1:0] MAG_MAX = {MAG_W{1'b1}};

    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } sm16_t;

    typedef struct packed {
        sm16_t result;
        logic  sat;
    } sm_sum_t;

    // Fold negative zero onto positive zero.
    function automatic sm16_t sm_norm(input sm16_t x);
        sm16_t r;
        r = x;
        if (x.mag == '0) begin
            r.sign = 1'b0;
        end
        return r;
    endfunction

    // Saturating add of normalised operands with precomputed sign/magnitude relations.
    function automatic sm_sum_t sm_add_sat_pre(input sm16_t a, input sm16_t b,
                                               input logic signs_equal, input logic a_ge_b);
        sm_sum_t          r;
        logic [MAG_W:0]   sum;
        r   = '0;
        sum = '0;
        if (signs_equal) begin
            sum = {1'b0, a.mag} + {1'b0, b.mag};
            r.result.sign = a.sign;
            if (sum[MAG_W]) begin
                r.result.mag = MAG_MAX;
                r.sat        = 1'b1;
            end else begin
                r.result.mag = sum[MAG_W-1:0];
            end
        end else if (a_ge_b) begin
            r.result.mag  = a.mag - b.mag;
            r.result.sign = a.sign;
        end else begin
            r.result.mag  = b.mag - a.mag;
            r.result.sign = b.sign;
        end
        // Every zero result leaves as +0.
        r.result = sm_norm(r.result);
        return r;
    endfunction

    // Self-contained saturating sign-magnitude add.
    function automatic sm_sum_t sm_add_sat(input sm16_t a, input sm16_t b);
        sm16_t na;
        sm16_t nb;
        na = sm_norm(a);
        nb = sm_norm(b);
        return sm_add_sat_pre(na, nb, na.sign == nb.sign, na.mag >= nb.mag);
    endfunction

endpackage

// File: rtl/subtractor_fixed_int16_pipe_sm_add_sat_core.sv
// Combinational sign-magnitude saturating adder core.
// Ports: a, b            - normalised operands
//        signs_equal     - a.sign == b.sign, precomputed upstream
//        a_ge_b          - a.mag >= b.mag, precomputed upstream
//        result_c, sat_c - sum and saturation flag (combinational)
module sm_add_sat_core
    import fixed_int16_pkg::*;
(
    input  sm16_t a,
    input  sm16_t b,
    input  logic  signs_equal,
    input  logic  a_ge_b,
    output sm16_t result_c,
    output logic  sat_c
);

    sm_sum_t sum;

    always_comb begin
        sum      = sm_add_sat_pre(a, b, signs_equal, a_ge_b);
        result_c = sum.result;
        sat_c    = sum.sat;
    end

endmodule

// File: rtl/subtractor_fixed_int16_pipe.sv
// Two-stage pipelined saturating sign-magnitude subtractor (A - B) with
// valid/ready handshakes and a sticky saturation event counter.
// Ports: CLK, RST (async, active-high)
//        in_valid/in_ready, A_in, B_in         - operand stream
//        out_valid/out_ready, result_out, sat_out - result stream
//        sat_count                              - saturated results delivered
module subtractor_fixed_int16_pipe
    import fixed_int16_pkg::sm16_t;
    import fixed_int16_pkg::sm_norm;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned SAT_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A_in,
    input  logic [WIDTH-1:0]     B_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result_out,
    output logic                 sat_out,
    output logic [SAT_CNT_W-1:0] sat_count
);

    localparam int unsigned SM_W = $bits(sm16_t);

    sm16_t a_n;
    sm16_t b_inv;
    logic  s2_load;
    logic  s1_load;

    logic  s1_valid;
    sm16_t s1_a;
    sm16_t s1_b;
    logic  s1_signs_equal;
    logic  s1_a_ge_b;

    sm16_t core_result;
    logic  core_sat;

    // Operand normalisation; B's sign is flipped so the core only adds.
    always_comb begin
        sm16_t b_n;
        a_n   = sm_norm(sm16_t'(SM_W'(A_in)));
        b_n   = sm_norm(sm16_t'(SM_W'(B_in)));
        b_inv = sm_norm('{sign: ~b_n.sign, mag: b_n.mag});
    end

    // Handshake: stage 2 frees when empty or draining; stage 1 when it can pass on.
    always_comb begin
        s2_load  = !out_valid || out_ready;
        s1_load  = !s1_valid || s2_load;
        in_ready = s1_load;
    end

    // Stage 1: operand capture and relation precompute.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid       <= 1'b0;
            s1_a           <= '0;
            s1_b           <= '0;
            s1_signs_equal <= 1'b0;
            s1_a_ge_b      <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a           <= a_n;
                s1_b           <= b_inv;
                s1_signs_equal <= (a_n.sign == b_inv.sign);
                s1_a_ge_b      <= (a_n.mag >= b_inv.mag);
            end
        end
    end

    sm_add_sat_core u_core (
        .a           (s1_a),
        .b           (s1_b),
        .signs_equal (s1_signs_equal),
        .a_ge_b      (s1_a_ge_b),
        .result_c    (core_result),
        .sat_c       (core_sat)
    );

    // Stage 2: result register; holds while the consumer stalls.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid  <= 1'b0;
            result_out <= '0;
            sat_out    <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result_out <= WIDTH'(core_result);
                sat_out    <= core_sat;
            end
        end
    end

    // Saturation events counted on delivery only; sticks at all-ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && sat_out && (sat_count != {SAT_CNT_W{1'b1}})) begin
            sat_count <= sat_count + SAT_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_subtractor_fixed_int16_pipe.sv
// Scoreboard bench for subtractor_fixed_int16_pipe: driver pushes expected
// results at input handshake, monitor pops and compares at output handshake.
module tb_subtractor_fixed_int16_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result_out;
    logic        sat_out;
    logic [7:0]  sat_count;

    typedef struct {
        logic [15:0] r;
        logic        s;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          total;
    int          bad;
    int          cyc;
    int          sat_model;
    logic        lat_chk;
    logic [15:0] drv_r;
    logic        drv_s;

    subtractor_fixed_int16_pipe #(.WIDTH(16), .SAT_CNT_W(8)) dut (
        .CLK        (clk),
        .RST        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A_in       (a_in),
        .B_in       (b_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_out (result_out),
        .sat_out    (sat_out),
        .sat_count  (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: records accepted pairs, checks delivered and stalled results.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (in_valid && in_ready) begin
                q.push_back('{r: drv_r, s: drv_s, acc: cyc});
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %h want none", result_out);
                end else if (out_ready) begin
                    e = q.pop_front();
                    chk("result", 32'(result_out), 32'(e.r));
                    chk("sat", 32'(sat_out), 32'(e.s));
                    if (lat_chk) chk("latency", 32'(cyc - e.acc), 32'd2);
                    if (e.s && sat_model != 255) sat_model++;
                end else begin
                    chk("stall_result", 32'(result_out), 32'(q[0].r));
                    chk("stall_sat", 32'(sat_out), 32'(q[0].s));
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] r, input logic s);
        logic ok;
        ok       = 1'b0;
        a_in     = a;
        b_in     = b;
        drv_r    = r;
        drv_s    = s;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no in_ready want in_ready for %h-%h", a, b);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total     = 0;
        bad       = 0;
        cyc       = 0;
        sat_model = 0;
        lat_chk   = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        drv_r     = '0;
        drv_s     = 1'b0;

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result_out), 32'h0000);
        chk("rst_sat", 32'(sat_out), 32'd0);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #20 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Saturating single pairs with latency checks.
        lat_chk = 1'b1;
        send(16'h4000, 16'hC000, 16'h7FFF, 1'b1);
        drain();
        send(16'hC000, 16'h4000, 16'hFFFF, 1'b1);
        drain();

        // Mixed signs, back to back.
        send(16'hC000, 16'hA000, 16'hA000, 1'b0);
        send(16'h2000, 16'hC000, 16'h6000, 1'b0);
        send(16'hA000, 16'hC000, 16'h2000, 1'b0);
        // Zero handling.
        send(16'h2000, 16'h2000, 16'h0000, 1'b0);
        send(16'h8000, 16'h0000, 16'h0000, 1'b0);
        send(16'h0001, 16'h8001, 16'h0002, 1'b0);
        drain();
        chk("sat_count_early", 32'(sat_count), 32'(sat_model));

        // Backpressure: consumer stalls for 3 cycles while 5 pairs stream in.
        lat_chk = 1'b0;
        fork
            begin
                send(16'h1000, 16'h0800, 16'h0800, 1'b0);
                send(16'h0800, 16'h1000, 16'h8800, 1'b0);
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                send(16'h7000, 16'hF000, 16'h7FFF, 1'b1);
                send(16'h9000, 16'h1000, 16'hA000, 1'b0);
                send(16'h0003, 16'h0003, 16'h0000, 1'b0);
            end
            begin
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_sat_count", 32'(sat_count), 32'(sat_model));

        // A stalled saturating result must not be counted before delivery.
        out_ready = 1'b0;
        send(16'h7FFF, 16'h8001, 16'h7FFF, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("stall_not_counted", 32'(sat_count), 32'(sat_model));
        out_ready = 1'b1;
        drain();
        chk("stall_then_counted", 32'(sat_count), 32'(sat_model));

        // Counter saturation.
        for (int i = 0; i < 260; i++) begin
            send(16'h7FFF, 16'h8001, 16'h7FFF, 1'b1);
        end
        drain();
        chk("sat_count_max", 32'(sat_count), 32'hFF);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_count_sticky", 32'(sat_count), 32'hFF);

        // Mid-stream reset with two items in flight.
        out_ready = 1'b0;
        send(16'h4000, 16'hC000, 16'h7FFF, 1'b1);
        send(16'h1000, 16'h0800, 16'h0800, 1'b0);
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_sat_count", 32'(sat_count), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        #2 rst = 1'b0;
        q.delete();
        sat_model = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        lat_chk = 1'b1;
        send(16'hC000, 16'hA000, 16'hA000, 1'b0);
        drain();
        chk("post_rst_sat_count", 32'(sat_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
